// File: rtl/scroll_msg_engine.sv
// rtl/scroll_msg_engine.sv - scrolling-text window generator for the ATM character display
//
// Holds MSG_COUNT programmable messages of CHAR_W-bit character codes and
// shifts the selected one, followed by TAIL_BLANKS blanks, through a
// WIN_CHARS-wide window, one character per sec_clock edge.
//
// Ports:
//   sec_clock    display tick, rising edge
//   rst          synchronous active-high reset
//   msg_sel      slot to play, sampled with start
//   start        request a pass (IDLE only)
//   loop         sampled with start: repeat until stop
//   stop         abort, blank the window
//   hold         freeze the scroll
//   cfg_we       write cfg_char to slot cfg_msg, index cfg_addr
//   cfg_len_we   write cfg_len (clamped to MAX_LEN) to slot cfg_msg
//   instruction  window, newest character in the low slice
//   busy         pass in progress
//   pass_done    one-cycle pulse at the end of each completed pass
module scroll_msg_engine #(
    parameter int CHAR_W      = 5,
    parameter int WIN_CHARS   = 8,
    parameter int MSG_COUNT   = 4,
    parameter int MAX_LEN     = 32,
    parameter int TAIL_BLANKS = 8,
    localparam int SEL_W  = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int W      = CHAR_W * WIN_CHARS
) (
    input  logic              sec_clock,
    input  logic              rst,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic              hold,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_msg,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CHAR_W-1:0] cfg_char,
    input  logic              cfg_len_we,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [W-1:0]      instruction,
    output logic              busy,
    output logic              pass_done
);

    localparam int DEPTH  = MSG_COUNT * MAX_LEN;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TCNT_W = $clog2(TAIL_BLANKS + 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SHIFT_MSG  = 2'd1;
    localparam logic [1:0] SHIFT_TAIL = 2'd2;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  len_q [MSG_COUNT];

    logic [1:0]        state;
    logic [W-1:0]      window;
    logic [SEL_W-1:0]  cur_msg;
    logic [LEN_W-1:0]  cur_len;
    logic              cur_loop;
    logic [ADDR_W-1:0] idx;
    logic [TCNT_W-1:0] tcnt;

    logic              msg_ok;
    logic              addr_ok;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [CHAR_W-1:0] cur_char;
    logic [LEN_W-1:0]  len_clamped;

    // Range guards only matter for non-power-of-two MSG_COUNT / MAX_LEN.
    assign msg_ok      = (int'(cfg_msg) < MSG_COUNT);
    assign addr_ok     = (int'(cfg_addr) < MAX_LEN);
    assign wr_addr     = AW'(cfg_msg) * AW'(MAX_LEN) + AW'(cfg_addr);
    assign rd_addr     = AW'(cur_msg) * AW'(MAX_LEN) + AW'(idx);
    assign cur_char    = mem[rd_addr];
    assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    assign instruction = window;
    assign busy        = (state != IDLE);

    // Character RAM is deliberately left out of reset; writes are live even
    // while the slot is being played.
    always_ff @(posedge sec_clock) begin
        if (cfg_we && msg_ok && addr_ok) begin
            mem[wr_addr] <= cfg_char;
        end
    end

    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state     <= IDLE;
            window    <= '0;
            pass_done <= 1'b0;
            cur_msg   <= '0;
            cur_len   <= '0;
            cur_loop  <= 1'b0;
            idx       <= '0;
            tcnt      <= '0;
            for (int i = 0; i < MSG_COUNT; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            pass_done <= 1'b0;
            if (cfg_len_we && msg_ok) begin
                len_q[cfg_msg] <= len_clamped;
            end

            if (stop) begin
                state  <= IDLE;
                window <= '0;
            end else if (!hold) begin
                case (state)
                    IDLE: begin
                        if (start && (len_q[msg_sel] != '0)) begin
                            cur_msg  <= msg_sel;
                            cur_len  <= len_q[msg_sel];
                            cur_loop <= loop;
                            idx      <= '0;
                            state    <= SHIFT_MSG;
                        end
                    end
                    SHIFT_MSG: begin
                        window <= {window[W-CHAR_W-1:0], cur_char};
                        if (LEN_W'(idx) == cur_len - LEN_W'(1)) begin
                            tcnt  <= '0;
                            state <= SHIFT_TAIL;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                    SHIFT_TAIL: begin
                        window <= {window[W-CHAR_W-1:0], {CHAR_W{1'b0}}};
                        tcnt   <= tcnt + TCNT_W'(1);
                        if (tcnt == TCNT_W'(TAIL_BLANKS - 1)) begin
                            pass_done <= 1'b1;
                            idx       <= '0;
                            // Looping re-enters SHIFT_MSG directly so the
                            // first character follows the last blank with no gap.
                            state     <= cur_loop ? SHIFT_MSG : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_msg_engine.sv
// tb/tb_scroll_msg_engine.sv - directed-vector bench for scroll_msg_engine
module tb_scroll_msg_engine;

    logic        sec_clock = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  msg_sel = '0;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        stop = 1'b0;
    logic        hold = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_msg = '0;
    logic [4:0]  cfg_addr = '0;
    logic [4:0]  cfg_char = '0;
    logic        cfg_len_we = 1'b0;
    logic [5:0]  cfg_len = '0;
    logic [39:0] instruction;
    logic        busy;
    logic        pass_done;

    int vectors = 0;
    int miscompares = 0;

    scroll_msg_engine dut (
        .sec_clock   (sec_clock),
        .rst         (rst),
        .msg_sel     (msg_sel),
        .start       (start),
        .loop        (loop),
        .stop        (stop),
        .hold        (hold),
        .cfg_we      (cfg_we),
        .cfg_msg     (cfg_msg),
        .cfg_addr    (cfg_addr),
        .cfg_char    (cfg_char),
        .cfg_len_we  (cfg_len_we),
        .cfg_len     (cfg_len),
        .instruction (instruction),
        .busy        (busy),
        .pass_done   (pass_done)
    );

    always #5 sec_clock = ~sec_clock;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge sec_clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_char(input logic [1:0] m, input logic [4:0] a, input logic [4:0] c);
        cfg_we = 1'b1; cfg_msg = m; cfg_addr = a; cfg_char = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input logic [1:0] m, input logic [5:0] l);
        cfg_len_we = 1'b1; cfg_msg = m; cfg_len = l;
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic lp);
        start = 1'b1; msg_sel = m; loop = lp;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [4:0] slot3_char(input int i);
        return 5'((i % 31) + 1);
    endfunction

    int pulses;
    logic [39:0] frozen;
    logic [39:0] exp_win;

    initial begin
        // Reset
        tick_n(2);
        check_vec("rst_instruction", 64'(instruction), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_pass_done", 64'(pass_done), 64'd0);
        rst = 1'b0;

        // Slot 0 = {1,2}; last char written together with its length
        wr_char(2'd0, 5'd0, 5'd1);
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_char = 5'd2;
        cfg_len_we = 1'b1; cfg_msg = 2'd0; cfg_len = 6'd2;
        tick();
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        wr_char(2'd1, 5'd0, 5'd9);
        wr_char(2'd1, 5'd1, 5'd14);
        wr_char(2'd1, 5'd2, 5'd16);
        wr_len(2'd1, 6'd3);

        // One-shot pass
        do_start(2'd0, 1'b0);                                   // edge k
        check_vec("oneshot_busy_k", 64'(busy), 64'd1);
        tick();                                                 // k+1
        check_vec("oneshot_first", 64'(instruction[4:0]), 64'd1);
        tick();                                                 // k+2
        check_vec("oneshot_two", 64'(instruction[9:0]), 64'd34);
        tick_n(7);                                              // k+9
        check_vec("oneshot_k9_pd", 64'(pass_done), 64'd0);
        check_vec("oneshot_k9_busy", 64'(busy), 64'd1);
        tick();                                                 // k+10
        check_vec("oneshot_pd", 64'(pass_done), 64'd1);
        check_vec("oneshot_busy_end", 64'(busy), 64'd0);
        check_vec("oneshot_blank", 64'(instruction), 64'd0);
        tick();
        check_vec("oneshot_pd_width", 64'(pass_done), 64'd0);

        // Looped pass on slot 1
        do_start(2'd1, 1'b1);                                   // k
        tick();                                                 // k+1
        check_vec("loop_first", 64'(instruction[4:0]), 64'd9);
        tick_n(10);                                             // k+11
        check_vec("loop_pd1", 64'(pass_done), 64'd1);
        check_vec("loop_busy", 64'(busy), 64'd1);
        check_vec("loop_blank", 64'(instruction), 64'd0);
        tick();                                                 // k+12
        check_vec("loop_nogap", 64'(instruction), 64'd9);
        check_vec("loop_pd_width", 64'(pass_done), 64'd0);
        do_start(2'd0, 1'b0);                                   // k+13, ignored
        tick_n(8);                                              // k+21
        check_vec("loop_k21_pd", 64'(pass_done), 64'd0);
        tick();                                                 // k+22
        check_vec("loop_pd2", 64'(pass_done), 64'd1);
        tick();                                                 // k+23
        check_vec("loop_restart", 64'(instruction), 64'd9);
        tick_n(4);                                              // k+27, in tail
        check_vec("tail_busy", 64'(busy), 64'd1);
        check_vec("tail_window", 64'(instruction), {24'd0, 5'd9, 5'd14, 5'd16, 10'd0});

        // Stop during tail
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_vec("stop_window", 64'(instruction), 64'd0);
        check_vec("stop_busy", 64'(busy), 64'd0);
        check_vec("stop_pd", 64'(pass_done), 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pass_done) pulses++;
        end
        check_vec("stop_no_pd", 64'(pulses), 64'd0);

        // Start and stop together in IDLE
        start = 1'b1; stop = 1'b1; msg_sel = 2'd0; loop = 1'b0;
        tick();
        start = 1'b0; stop = 1'b0;
        check_vec("startstop_busy", 64'(busy), 64'd0);
        tick();
        check_vec("startstop_busy2", 64'(busy), 64'd0);

        // Hold for 5 cycles mid-message
        do_start(2'd0, 1'b0);                                   // k
        tick();                                                 // k+1
        frozen = instruction;
        check_vec("hold_pre", 64'(instruction[4:0]), 64'd1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();                                             // k+2..k+6
            check_vec($sformatf("hold_frozen%0d", i), 64'(instruction), 64'(frozen));
        end
        hold = 1'b0;
        tick();                                                 // k+7
        check_vec("hold_resume", 64'(instruction[9:0]), 64'd34);
        tick_n(7);                                              // k+14
        check_vec("hold_k14_pd", 64'(pass_done), 64'd0);
        tick();                                                 // k+15
        check_vec("hold_pd", 64'(pass_done), 64'd1);
        check_vec("hold_busy_end", 64'(busy), 64'd0);

        // Length-0 slot is ignored
        do_start(2'd2, 1'b0);
        check_vec("len0_busy", 64'(busy), 64'd0);
        tick_n(3);
        check_vec("len0_pd", 64'(pass_done), 64'd0);

        // Slot 3: 32 characters, length written as 40 clamps to 32
        for (int i = 0; i < 32; i++) wr_char(2'd3, 5'(i), slot3_char(i));
        wr_len(2'd3, 6'd40);
        do_start(2'd3, 1'b0);                                   // k
        tick_n(32);                                             // k+32
        exp_win = '0;
        for (int j = 24; j < 32; j++) exp_win = {exp_win[34:0], slot3_char(j)};
        check_vec("clamp_window", 64'(instruction), 64'(exp_win));
        tick_n(7);                                              // k+39
        check_vec("clamp_k39_pd", 64'(pass_done), 64'd0);
        check_vec("clamp_k39_busy", 64'(busy), 64'd1);
        tick();                                                 // k+40
        check_vec("clamp_pd", 64'(pass_done), 64'd1);
        check_vec("clamp_busy_end", 64'(busy), 64'd0);

        // Reset mid SHIFT_MSG with start asserted alongside
        do_start(2'd3, 1'b0);
        tick_n(3);
        check_vec("prerst_busy", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b1; msg_sel = 2'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check_vec("midrst_instruction", 64'(instruction), 64'd0);
        check_vec("midrst_busy", 64'(busy), 64'd0);
        check_vec("midrst_pd", 64'(pass_done), 64'd0);
        tick();
        check_vec("midrst_no_start", 64'(busy), 64'd0);
        // All lengths cleared: starting any previously programmed slot is ignored
        do_start(2'd0, 1'b0);
        check_vec("rst_len0_slot0", 64'(busy), 64'd0);
        do_start(2'd3, 1'b0);
        check_vec("rst_len0_slot3", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
